// File: rtl/smul_arbiter.sv
// smul_arbiter: round-robin arbiter with optional bounded lock sharing one 18x18 interpolating multiplier
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid[N], req_lock[N]       per-requester operand valid and keep-grant request
//   req_a/req_b/req_scale[N*18]     signed operands, slice i at [18i+17:18i]
//   req_ready[N]                    one-hot accept, combinational
//   resp_valid, resp_id, resp_data  registered result a + (((b-a)*scale) >>> 16) tagged with owner
module smul_arbiter #(
    parameter int N        = 4,
    parameter int MAX_LOCK = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_lock,
    input  logic [N*18-1:0]      req_a,
    input  logic [N*18-1:0]      req_b,
    input  logic [N*18-1:0]      req_scale,
    output logic [N-1:0]         req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic signed [35:0]   resp_data
);
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, lock_owner_q, lock_owner_d, gnt, idx;
    logic           lock_v_q, lock_v_d, gnt_v, lock_hit, yield, xfer;
    logic [3:0]     lock_cnt_q, lock_cnt_d;
    logic [17:0]    a_s, b_s, s_s;
    logic signed [35:0] a_x, b_x, s_x, prod, res;
    logic           resp_valid_q;
    logic [IDW-1:0] resp_id_q;
    logic signed [35:0] resp_data_q;

    // the owner keeps the multiplier only while it stays valid and under the lock limit
    always_comb begin
        lock_hit = lock_v_q && req_valid[lock_owner_q] && (lock_cnt_q < 4'(MAX_LOCK));
        yield    = lock_v_q && req_valid[lock_owner_q] && (lock_cnt_q >= 4'(MAX_LOCK));
        gnt      = lock_owner_q;
        gnt_v    = lock_hit;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(rr_ptr_q) + k) % N);
            if (!gnt_v && req_valid[idx]) begin
                gnt_v = 1'b1;
                gnt   = idx;
            end
        end
        xfer      = gnt_v && !rst;
        req_ready = xfer ? (N'(1) << gnt) : '0;
    end

    always_comb begin
        a_s = '0;
        b_s = '0;
        s_s = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == gnt) begin
                a_s = req_a[18*i +: 18];
                b_s = req_b[18*i +: 18];
                s_s = req_scale[18*i +: 18];
            end
        end
        a_x  = {{18{a_s[17]}}, a_s};
        b_x  = {{18{b_s[17]}}, b_s};
        s_x  = {{18{s_s[17]}}, s_s};
        // |b-a| < 2^18 and |scale| <= 2^17, so the product always fits 36 bits
        prod = (b_x - a_x) * s_x;
        res  = a_x + (prod >>> 16);
    end

    // a forced yield clears the lock even if the winner asks to lock in the same cycle
    always_comb begin
        rr_ptr_d     = xfer ? ((gnt == IDW'(N-1)) ? '0 : gnt + 1'b1) : rr_ptr_q;
        lock_v_d     = xfer ? (req_lock[gnt] && !yield) : lock_v_q;
        lock_owner_d = (xfer && req_lock[gnt] && !yield) ? gnt : lock_owner_q;
        lock_cnt_d   = !xfer ? lock_cnt_q :
                       (!req_lock[gnt] || yield) ? 4'd0 :
                       lock_hit ? lock_cnt_q + 4'd1 : 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_v_q     <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_v_q     <= lock_v_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= xfer;
            if (xfer) begin
                resp_id_q   <= gnt;
                resp_data_q <= res;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_smul_arbiter.sv
// tb_smul_arbiter: scoreboard bench for smul_arbiter (N=4, MAX_LOCK=8)
module tb_smul_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  va = '0, la = '0;
    int          ia[4], ib[4], sc[4];
    logic [71:0] req_a, req_b, req_scale;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [35:0] resp_data;
    int          total = 0, bad = 0;

    typedef struct {logic [1:0] id; logic [35:0] d;} exp_t;
    exp_t sb[$];

    smul_arbiter #(.N(4), .MAX_LOCK(8)) dut (
        .clk(clk), .rst(rst), .req_valid(va), .req_lock(la),
        .req_a(req_a), .req_b(req_b), .req_scale(req_scale),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[18*i +: 18]     = 18'(ia[i]);
            req_b[18*i +: 18]     = 18'(ib[i]);
            req_scale[18*i +: 18] = 18'(sc[i]);
        end
    end

    function automatic logic [35:0] model(int a, int b, int s);
        longint p, q;
        p = longint'(b - a) * longint'(s);
        q = p / 65536;
        if (p < 0 && q * 65536 != p) q = q - 1;
        return 36'(longint'(a) + q);
    endfunction

    task automatic push_exp(int g);
        sb.push_back('{2'(g), model(ia[g], ib[g], sc[g])});
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops;
        for (int i = 0; i < 4; i++) begin
            ia[i] = int'($urandom_range(0, 262143)) - 131072;
            ib[i] = int'($urandom_range(0, 262143)) - 131072;
            sc[i] = int'($urandom_range(0, 262143)) - 131072;
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected got id=%0d data=%h want=none", resp_id, resp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (resp_id !== e.id || resp_data !== e.d) begin
                    bad++;
                    $display("FAIL resp got id=%0d data=%h want id=%0d data=%h", resp_id, resp_data, e.id, e.d);
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        va = 4'hf;
        rand_ops();
        next_cycle();
        next_cycle();
        @(negedge clk);
        total += 4;
        if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
        if (resp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", resp_id); end
        if (resp_data !== 36'd0) begin bad++; $display("FAIL reset_data got=%h want=0", resp_data); end
        next_cycle();
        rst = 1'b0;
        va = '0;
    endtask

    task automatic test_single;
        va = 4'b0001;
        ia[0] = 1000; ib[0] = 3000; sc[0] = 32768;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL single0_ready got=%b want=0001", req_ready); end
        push_exp(0);
        next_cycle();
        va = 4'b0100;
        ia[2] = 0; ib[2] = -32768; sc[2] = 65535;
        @(negedge clk);
        total += 2;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL single2_ready got=%b want=0100", req_ready); end
        if (resp_data !== 36'd2000) begin bad++; $display("FAIL single0_data got=%h want=%h", resp_data, 36'd2000); end
        push_exp(2);
        next_cycle();
        va = '0;
        @(negedge clk);
        total += 2;
        if (req_ready !== 4'b0) begin bad++; $display("FAIL single_idle_ready got=%b want=0000", req_ready); end
        if (resp_data !== 36'hF_FFFF_8000) begin bad++; $display("FAIL single2_floor got=%h want=fffff8000", resp_data); end
        next_cycle();
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b want=0", resp_valid); end
        next_cycle();
    endtask

    task automatic test_round_robin;
        int cnt[4];
        int seq[6];
        cnt = '{default: 0};
        seq = '{0, 2, 3, 0, 2, 3};
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        va = 4'hf;
        la = '0;
        for (int k = 0; k < 40; k++) begin
            rand_ops();
            @(negedge clk);
            total++;
            if (req_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_order k=%0d got=%b want=%b", k, req_ready, 4'(1 << (k % 4))); end
            for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
            push_exp(k % 4);
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cnt[i] !== 10) begin bad++; $display("FAIL rr_share idx=%0d got=%0d want=10", i, cnt[i]); end
        end
        va = 4'b1101;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            @(negedge clk);
            total++;
            if (req_ready !== 4'(1 << seq[k])) begin bad++; $display("FAIL rr_skip k=%0d got=%b want=%b", k, req_ready, 4'(1 << seq[k])); end
            push_exp(seq[k]);
            next_cycle();
        end
        va = '0;
    endtask

    task automatic test_lock_chain;
        int exp_b[4];
        logic lk[4];
        exp_b = '{8000, 4000, 2000, 1000};
        lk = '{1'b1, 1'b1, 1'b1, 1'b0};
        rand_ops();
        va = 4'hf;
        la = 4'b0010;
        ia[1] = 0; ib[1] = 16000; sc[1] = 32768;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL chain_pre got=%b want=0001", req_ready); end
        push_exp(0);
        next_cycle();
        for (int s = 0; s < 4; s++) begin
            la[1] = lk[s];
            if (s > 0) ib[1] = int'($signed(resp_data));
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0010) begin bad++; $display("FAIL chain_grant s=%0d got=%b want=0010", s, req_ready); end
            if (s > 0) begin
                total++;
                if (ib[1] !== exp_b[s-1]) begin bad++; $display("FAIL chain_b s=%0d got=%0d want=%0d", s, ib[1], exp_b[s-1]); end
            end
            sb.push_back('{2'd1, 36'(exp_b[s])});
            next_cycle();
        end
        la = '0;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL chain_after got=%b want=0100", req_ready); end
        push_exp(2);
        next_cycle();
        va = '0;
    endtask

    task automatic test_forced_yield;
        int g;
        va = 4'b1001;
        la = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            rand_ops();
            g = (k % 9 == 8) ? 0 : 3;
            @(negedge clk);
            total++;
            if (req_ready !== 4'(1 << g)) begin bad++; $display("FAIL yield k=%0d got=%b want=%b", k, req_ready, 4'(1 << g)); end
            push_exp(g);
            next_cycle();
        end
        va = '0;
        la = '0;
    endtask

    task automatic test_reset_mid;
        int seq[4];
        seq = '{3, 0, 1, 1};
        va = 4'hf;
        la = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            @(negedge clk);
            total++;
            if (req_ready !== 4'(1 << seq[k])) begin bad++; $display("FAIL mid_pre k=%0d got=%b want=%b", k, req_ready, 4'(1 << seq[k])); end
            push_exp(seq[k]);
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0000", req_ready); end
        next_cycle();
        rst = 1'b0;
        va = '0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid1 got=%b want=0", resp_valid); end
        next_cycle();
        va = 4'hf;
        @(negedge clk);
        total += 2;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid2 got=%b want=0", resp_valid); end
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first got=%b want=0001", req_ready); end
        push_exp(0);
        next_cycle();
        va = '0;
        la = '0;
    endtask

    task automatic test_idle_hold;
        logic [35:0] exp_d;
        rand_ops();
        va = 4'b0010;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL idle_xfer got=%b want=0010", req_ready); end
        push_exp(1);
        exp_d = model(ia[1], ib[1], sc[1]);
        next_cycle();
        va = '0;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0) begin bad++; $display("FAIL idle_ready k=%0d got=%b want=0000", k, req_ready); end
            if (k > 0) begin
                total += 3;
                if (resp_valid !== 1'b0) begin bad++; $display("FAIL idle_valid k=%0d got=%b want=0", k, resp_valid); end
                if (resp_id !== 2'd1) begin bad++; $display("FAIL idle_id k=%0d got=%0d want=1", k, resp_id); end
                if (resp_data !== exp_d) begin bad++; $display("FAIL idle_data k=%0d got=%h want=%h", k, resp_data, exp_d); end
            end
            next_cycle();
        end
        va = 4'hf;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL idle_rrptr got=%b want=0100", req_ready); end
        push_exp(2);
        next_cycle();
        va = '0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock_chain();
        test_forced_yield();
        test_reset_mid();
        test_idle_hold();
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
